// File: rtl/instruction_fetch.sv
// Instruction fetch: IDLE -> FETCH (request IMem at PC) -> ISSUE (hold IR for the control unit) -> FETCH.
// Latency: InstrValid rises one cycle after IMemAck; the next request starts the cycle after InstrDone.
// Backpressure: ISSUE holds IR/InstrValid until InstrDone; FETCH waits for IMemAck (FETCH_TIMEOUT_EN adds a 16-cycle timeout).
module instruction_fetch (
  input  logic        CLK,
  input  logic        Reset,
  output logic        IMemReq,
  output logic [15:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [15:0] IMemData,
  output logic        InstrValid,
  output logic [4:0]  OPCODE,
  output logic        flagbit,
  output logic [9:0]  Immediate,
  input  logic        InstrDone,
  input  logic        PCWrite,
  input  logic [15:0] PCTarget,
  output logic [15:0] PC,
  output logic        FetchErr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetchState_t;

  fetchState_t state;
  fetchState_t nextState;

  logic [15:0] pcReg;
  logic [15:0] irReg;
  logic        ackTaken;   // IR load strobe: ack accepted while a request is out
  logic        retire;     // PC update strobe: InstrDone accepted in ISSUE
  logic        reqHold;    // one-cycle request drop after a fetch timeout

  // State register; reset parks the FSM in IDLE from any state.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and strobe decode; InstrDone/PCWrite only matter in ISSUE, IMemAck only in FETCH.
  always_comb begin
    nextState  = state;
    IMemReq    = 1'b0;
    InstrValid = 1'b0;
    ackTaken   = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        nextState = FETCH;
      end
      FETCH: begin
        IMemReq = !reqHold;
        if (IMemAck && !reqHold) begin
          ackTaken  = 1'b1;
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        InstrValid = 1'b1;
        if (InstrDone) begin
          retire    = 1'b1;
          nextState = FETCH;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // PC and IR: IR captures on accepted ack, PC advances (wrapping) or redirects on retire.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pcReg <= 16'h0000;
      irReg <= 16'h0000;
    end else begin
      if (ackTaken) begin
        irReg <= IMemData;
      end
      if (retire) begin
        pcReg <= PCWrite ? PCTarget : pcReg + 16'd1;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] missCnt;
  logic       errFlag;
  logic       timeoutHit;

  // Sixteenth consecutive unacked request cycle (counter already at 15 and still no ack).
  assign timeoutHit = (state == FETCH) && !reqHold && !IMemAck && (missCnt == 4'd15);

  // Miss counter, request holdoff and sticky error; counter is zero on FETCH entry and after ack/timeout.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      missCnt <= 4'd0;
      reqHold <= 1'b0;
      errFlag <= 1'b0;
    end else begin
      reqHold <= timeoutHit;
      if (timeoutHit) begin
        errFlag <= 1'b1;
      end
      if ((state != FETCH) || reqHold || IMemAck || timeoutHit) begin
        missCnt <= 4'd0;
      end else begin
        missCnt <= missCnt + 4'd1;
      end
    end
  end

  assign FetchErr = errFlag;
`else
  assign reqHold  = 1'b0;
  assign FetchErr = 1'b0;
`endif

  assign IMemAddr  = pcReg;
  assign PC        = pcReg;
  assign OPCODE    = irReg[15:11];
  assign flagbit   = irReg[10];
  assign Immediate = irReg[9:0];

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK  in  1  rising-edge clock; Reset  in  1  synchronous active-high reset.
REQ-002 The block SHALL expose IMemReq  out  1  instruction memory read request.
REQ-003 The block SHALL expose IMemAddr  out  16  instruction memory word address, equal to PC.
REQ-004 The block SHALL accept IMemAck  in  1  memory data valid this cycle.
REQ-005 The block SHALL accept IMemData  in  16  instruction word.
REQ-006 The block SHALL expose InstrValid  out  1  decoded fields valid for the control unit.
REQ-007 The block SHALL expose OPCODE  out  5  IR[15:11], feeding control_unit OPCODE.
REQ-008 The block SHALL expose flagbit  out  1  IR[10], the "@" variant bit, feeding control_unit flagbit.
REQ-009 The block SHALL expose Immediate  out  10  IR[9:0], zero-extended downstream.
REQ-010 The block SHALL accept InstrDone  in  1  control unit has retired the current instruction.
REQ-011 The block SHALL accept PCWrite  in  1  redirect the PC; sampled only with InstrDone.
REQ-012 The block SHALL accept PCTarget  in  16  redirect address from the datapath PCSrc mux.
REQ-013 The block SHALL expose PC  out  16  current instruction address; the datapath uses it for the JFNC return address.
REQ-014 The block SHALL expose FetchErr  out  1  sticky fetch-timeout flag.

Function
REQ-015 FSM states SHALL be IDLE, FETCH and ISSUE, with IDLE->FETCH unconditionally on the next clock.
REQ-016 IMemReq SHALL be 1 only in FETCH, with IMemAddr=PC held stable while IMemReq=1.
REQ-017 FETCH with IMemAck=1 SHALL load IR<=IMemData and go to ISSUE; InstrValid SHALL rise the cycle after the ack (latency 1).
REQ-018 ISSUE SHALL hold InstrValid=1 and IR constant until InstrDone=1.
REQ-019 ISSUE with InstrDone=1 SHALL apply PC<=PCTarget if PCWrite=1, else PC<=PC+1, then go to FETCH.
REQ-020 PC+1 SHALL wrap modulo 2^16 (0xFFFF->0x0000).
REQ-021 PCWrite/PCTarget without InstrDone SHALL be ignored; InstrDone outside ISSUE SHALL be ignored.
REQ-022 IMemAck outside FETCH SHALL be ignored, with IR unchanged.
REQ-023 InstrValid SHALL be 0 in IDLE and FETCH; OPCODE/flagbit/Immediate SHALL always reflect IR, including stale values.
REQ-024 The earliest next request after retire SHALL be the cycle following InstrDone, giving no back-to-back IMemReq/InstrValid overlap.

Reset
REQ-025 Reset=1 on a rising edge SHALL force state=IDLE, PC=0x0000, IR=0x0000 and FetchErr=0 from any state, including mid-fetch and mid-issue.
REQ-026 During Reset, IMemReq=0 and InstrValid=0; IMemReq=1 with IMemAddr=0x0000 SHALL occur the first cycle after IDLE->FETCH.

Configuration
REQ-027 With FETCH_TIMEOUT_EN defined, a 4-bit counter SHALL count consecutive FETCH cycles without IMemAck, clearing on entry to FETCH and on ack.
REQ-028 With FETCH_TIMEOUT_EN defined, reaching 16 unacked cycles SHALL set FetchErr (sticky until Reset), drop IMemReq for exactly one cycle, then re-request the same PC.
REQ-029 Without FETCH_TIMEOUT_EN, FetchErr SHALL be tied 0, no counter SHALL exist, and FETCH SHALL wait indefinitely.

Verification
REQ-030 Reset 3 cycles, release, ack 2 cycles later with 0x0400 -> IMemAddr=0x0000; InstrValid=1 one cycle after ack; OPCODE=00000, flagbit=1, Immediate=0x000.
REQ-031 ISSUE IR=0x3800, InstrDone=1 with PCWrite=0 -> PC=0x0001; next IMemReq addresses 0x0001.
REQ-032 Retire with PCWrite=1, PCTarget=0x1234 -> next IMemAddr=0x1234; PCWrite=1 pulsed alone two cycles earlier -> no PC change.
REQ-033 PC=0xFFFF, retire without redirect -> PC=0x0000; Reset asserted during ISSUE -> InstrValid=0 next cycle, PC=0x0000.
REQ-034 FETCH_TIMEOUT_EN: withhold ack for 16 cycles -> FetchErr=1, IMemReq low for one cycle then high with same address; a later ack proceeds normally while FetchErr stays 1.
